// File: rtl/razor_pipe_reg_param.sv
// rtl/razor_pipe_reg_param.sv - parametrised Razor-style pipeline stage register with shadow compare and recovery
//
// Purpose:
//   One pipeline stage register split into NFIELD independently checked fields.
//   The main register samples d on the rising edge. The shadow register samples
//   the same d on the following falling edge. A main/shadow difference on a valid
//   payload means the data settled late. The stage then either restores the main
//   register from the shadow (MODE 0) or bubbles the stage (MODE 1). It holds
//   upstream for RECOV_CYC cycles and counts the event in a saturating counter.
//
// Ports:
//   clk        in   stage clock; main on posedge, shadow on negedge
//   reset      in   asynchronous active-low reset
//   d          in   payload, field i = d[i*FIELD_W +: FIELD_W]
//   valid_in   in   payload valid
//   stall_in   in   downstream hold; stage does not load while high
//   flush_in   in   pipeline flush; bubbles this stage, aborts recovery
//   cnt_clr    in   synchronous clear of err_cnt
//   q          out  registered payload
//   valid_out  out  registered valid
//   err_vec    out  per-field mismatch flags of the current error event
//   err_out    out  high for the whole recovery window
//   stall_out  out  upstream must hold d/valid_in while high
//   err_cnt    out  saturating count of error events

module razor_pipe_reg_param #(
    parameter int FIELD_W   = 32,
    parameter int NFIELD    = 4,
    parameter int MODE      = 0,
    parameter int RECOV_CYC = 1,
    parameter int CNT_W     = 8,
    localparam int W        = NFIELD * FIELD_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [W-1:0]      d,
    input  logic              valid_in,
    input  logic              stall_in,
    input  logic              flush_in,
    input  logic              cnt_clr,
    output logic [W-1:0]      q,
    output logic              valid_out,
    output logic [NFIELD-1:0] err_vec,
    output logic              err_out,
    output logic              stall_out,
    output logic [CNT_W-1:0]  err_cnt
);

    // The recovery down-counter needs at least one bit, even for a one-cycle window.
    localparam int RW = (RECOV_CYC > 1) ? $clog2(RECOV_CYC) : 1;

    typedef enum logic {
        IDLE    = 1'b0,
        RECOVER = 1'b1
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [W-1:0]        shadow;
    logic                loaded;
    logic [RW-1:0]       rcnt;
    logic [NFIELD-1:0]   mism;
    logic                any_mism;
    logic                err_event;
    logic                rcnt_zero;

    // Per-field compare. The shadow only differs meaningfully from q after the
    // falling edge of a cycle that loaded. Therefore the compare is gated by
    // loaded and is only used at the next rising edge. The loaded flag is never
    // set during RECOVER, so the compare is quiet there.
    for (genvar i = 0; i < NFIELD; i++) begin : g_cmp
        assign mism[i] = loaded & valid_out &
                         (q[i*FIELD_W +: FIELD_W] != shadow[i*FIELD_W +: FIELD_W]);
    end

    assign any_mism  = |mism;
    // An event is counted even when a flush at the same edge wins over recovery.
    assign err_event = (state == IDLE) & any_mism;
    assign rcnt_zero = (rcnt == '0);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!flush_in && any_mism) begin
                    state_nxt = RECOVER;
                end
            end
            RECOVER: begin
                if (flush_in || rcnt_zero) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: Moore outputs
    // ------------------------------------------------------------------
    always_comb begin
        stall_out = 1'b0;
        err_out   = 1'b0;
        if (state == RECOVER) begin
            stall_out = 1'b1;
            err_out   = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Main register, valid and error vector.
    // Priority: flush > error restore/bubble > normal load.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q         <= '0;
            valid_out <= 1'b0;
            err_vec   <= '0;
            loaded    <= 1'b0;
        end else begin
            loaded <= 1'b0;
            if (flush_in) begin
                q         <= '0;
                valid_out <= 1'b0;
                err_vec   <= '0;
            end else if (state == IDLE) begin
                if (any_mism) begin
                    err_vec <= mism;
                    if (MODE == 0) begin
                        // The shadow holds the value that finally settled.
                        q <= shadow;
                    end else begin
                        q         <= '0;
                        valid_out <= 1'b0;
                    end
                end else if (!stall_in) begin
                    q         <= d;
                    valid_out <= valid_in;
                    loaded    <= 1'b1;
                end
            end else begin
                if (rcnt_zero) begin
                    err_vec <= '0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Shadow register: captures d half a cycle after a load, else holds.
    // ------------------------------------------------------------------
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            shadow <= '0;
        end else if (loaded) begin
            shadow <= d;
        end
    end

    // ------------------------------------------------------------------
    // Recovery window down-counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rcnt <= '0;
        end else if (flush_in) begin
            rcnt <= '0;
        end else if (state == IDLE) begin
            if (any_mism) begin
                rcnt <= RW'(RECOV_CYC - 1);
            end
        end else if (!rcnt_zero) begin
            rcnt <= rcnt - RW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Saturating error event counter. Several fields that fail together
    // count as one event. A clear at the same edge as an event leaves a
    // count of one, so that event is not lost.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_cnt <= '0;
        end else if (cnt_clr) begin
            err_cnt <= err_event ? CNT_W'(1) : '0;
        end else if (err_event && (err_cnt != {CNT_W{1'b1}})) begin
            err_cnt <= err_cnt + CNT_W'(1);
        end
    end

endmodule
